// File: rtl/fft_frame_sched_pkg.sv
// Shared types and helpers for the FFT frame scheduler.
package fft_frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_UNLOAD   = 2'd3
  } fsm_state_t;

  // Smallest r with 2**r >= n; 0 for n <= 1.
  function automatic int unsigned ceil_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_sched_rr_arbiter.sv
// Round-robin grant: first requesting channel strictly after the last grant, wrapping.
module fft_rr_arbiter
  import fft_frame_sched_pkg::*;
#(
  parameter  int unsigned NCH = 4,
  localparam int unsigned CHW = (NCH > 1) ? ceil_log2(NCH) : 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [NCH-1:0] i_last_gnt,
  output logic [NCH-1:0] o_gnt,
  output logic [CHW-1:0] o_gnt_idx,
  output logic           o_any
);

  logic [CHW-1:0] w_last_idx;
  logic [CHW-1:0] w_idx;
  logic           w_found;

  assign o_any = |i_req;

  always_comb begin
    w_last_idx = '0;
    w_idx      = '0;
    w_found    = 1'b0;
    o_gnt      = '0;
    o_gnt_idx  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (i_last_gnt[CHW'(i)]) w_last_idx = CHW'(i);
    end
    // Offset 1..NCH from the last grant; offset NCH revisits the last grant itself.
    for (int unsigned k = 1; k <= NCH; k++) begin
      w_idx = CHW'((32'(w_last_idx) + k) % NCH);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Time-shares one FFT core between NCH ADC channel FIFOs, one frame in flight,
// and tags each result sample with its channel and bin.
module fft_frame_sched
  import fft_frame_sched_pkg::*;
#(
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned POINTS  = 256,
  parameter  int unsigned WIDTH   = 18,
  parameter  int unsigned TIMEOUT = 65535,
  localparam int unsigned LOGPTS  = ceil_log2(POINTS),
  localparam int unsigned EXPW    = ceil_log2(LOGPTS) + 1,
  localparam int unsigned CHW     = (NCH > 1) ? ceil_log2(NCH) : 1,
  localparam int unsigned TOW     = ceil_log2(TIMEOUT + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_grst,
  input  logic [NCH-1:0]       i_ch_req,
  input  logic [NCH*WIDTH-1:0] i_ch_data,
  output logic [NCH-1:0]       o_ch_rd,
  input  logic                 i_fft_buf_ready,
  output logic                 o_fft_datai_valid,
  output logic [WIDTH-1:0]     o_fft_datai_re,
  output logic [WIDTH-1:0]     o_fft_datai_im,
  input  logic                 i_fft_outp_ready,
  output logic                 o_fft_read_outp,
  input  logic                 i_fft_datao_valid,
  input  logic [WIDTH-1:0]     i_fft_datao_re,
  input  logic [WIDTH-1:0]     i_fft_datao_im,
  input  logic [EXPW-1:0]      i_fft_scale_exp,
  output logic                 o_out_valid,
  output logic [WIDTH-1:0]     o_out_re,
  output logic [WIDTH-1:0]     o_out_im,
  output logic [EXPW-1:0]      o_out_exp,
  output logic [CHW-1:0]       o_out_ch,
  output logic [LOGPTS-1:0]    o_out_bin,
  output logic                 o_out_last,
  input  logic                 i_out_ready,
  output logic                 o_err,
  output logic [15:0]          o_frame_cnt
);

  fsm_state_t        r_state;
  logic [CHW-1:0]    r_grant;
  logic [NCH-1:0]    r_last_gnt;
  logic [LOGPTS-1:0] r_smp_cnt;
  logic [LOGPTS-1:0] r_bin_cnt;
  logic [TOW-1:0]    r_to_cnt;
  logic              r_err;
  logic [15:0]       r_frame_cnt;
  logic              r_read_outp;
  logic              r_out_valid;
  logic              r_out_last;
  logic [WIDTH-1:0]  r_out_re;
  logic [WIDTH-1:0]  r_out_im;
  logic [EXPW-1:0]   r_out_exp;
  logic [CHW-1:0]    r_out_ch;
  logic [LOGPTS-1:0] r_out_bin;

  logic [NCH-1:0]    w_arb_gnt;
  logic [CHW-1:0]    w_arb_idx;
  logic              w_arb_any;
  logic              w_in_load;
  logic              w_load_stb;

  fft_rr_arbiter #(.NCH(NCH)) u_arb (
    .i_req      (i_ch_req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_arb_gnt),
    .o_gnt_idx  (w_arb_idx),
    .o_any      (w_arb_any)
  );

  // Load strobes follow BUF_READY in the same cycle; reset forces them low immediately.
  always_comb begin
    w_in_load         = (r_state == ST_LOAD) && !i_grst;
    w_load_stb        = w_in_load && i_fft_buf_ready;
    o_ch_rd           = '0;
    o_fft_datai_valid = w_load_stb;
    o_fft_datai_re    = '0;
    if (w_load_stb) o_ch_rd[r_grant] = 1'b1;
    if (w_in_load)  o_fft_datai_re = i_ch_data[32'(r_grant)*WIDTH +: WIDTH];
  end

  assign o_fft_datai_im = '0;

  always_ff @(posedge i_clk) begin
    if (i_grst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_last_gnt  <= NCH'(1) << (NCH - 1);
      r_smp_cnt   <= '0;
      r_bin_cnt   <= '0;
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
      r_read_outp <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_exp   <= '0;
      r_out_ch    <= '0;
      r_out_bin   <= '0;
    end else begin
      r_read_outp <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_grant    <= w_arb_idx;
            r_last_gnt <= w_arb_gnt;
            r_smp_cnt  <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // CH_REQ is not consulted here: a granted frame always completes.
          if (i_fft_buf_ready) begin
            if (r_smp_cnt == LOGPTS'(POINTS - 1)) begin
              r_smp_cnt <= '0;
              r_to_cnt  <= '0;
              r_state   <= ST_WAIT_RES;
            end else begin
              r_smp_cnt <= r_smp_cnt + LOGPTS'(1);
            end
          end
        end
        ST_WAIT_RES: begin
          if (i_fft_outp_ready && i_out_ready) begin
            r_read_outp <= 1'b1;
            r_out_exp   <= i_fft_scale_exp;
            r_bin_cnt   <= '0;
            r_state     <= ST_UNLOAD;
          end else if (r_to_cnt == TOW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TOW'(1);
          end
        end
        ST_UNLOAD: begin
          if (i_fft_datao_valid) begin
            r_out_valid <= 1'b1;
            r_out_re    <= i_fft_datao_re;
            r_out_im    <= i_fft_datao_im;
            r_out_ch    <= r_grant;
            r_out_bin   <= r_bin_cnt;
            r_out_last  <= (r_bin_cnt == LOGPTS'(POINTS - 1));
            if (r_bin_cnt == LOGPTS'(POINTS - 1)) begin
              r_bin_cnt   <= '0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= ST_IDLE;
            end else begin
              r_bin_cnt <= r_bin_cnt + LOGPTS'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_fft_read_outp = r_read_outp;
  assign o_out_valid     = r_out_valid;
  assign o_out_re        = r_out_re;
  assign o_out_im        = r_out_im;
  assign o_out_exp       = r_out_exp;
  assign o_out_ch        = r_out_ch;
  assign o_out_bin       = r_out_bin;
  assign o_out_last      = r_out_last;
  assign o_err           = r_err;
  assign o_frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Frame-level bench for fft_frame_sched: table of frames plus reset and timeout sequences.
module tb_fft_frame_sched;

  localparam int unsigned NCH = 4, POINTS = 256, WIDTH = 18, TIMEOUT = 100;
  localparam int unsigned LOGPTS = 8, EXPW = 4, CHW = 2;

  logic                 clk = 1'b0;
  logic                 grst;
  logic [NCH-1:0]       ch_req;
  logic [NCH*WIDTH-1:0] ch_data;
  logic [NCH-1:0]       ch_rd;
  logic                 buf_ready;
  logic                 dvalid;
  logic [WIDTH-1:0]     datai_re, datai_im;
  logic                 outp_ready;
  logic                 read_outp;
  logic                 datao_valid;
  logic [WIDTH-1:0]     datao_re, datao_im;
  logic [EXPW-1:0]      scale_exp;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_re, out_im;
  logic [EXPW-1:0]      out_exp;
  logic [CHW-1:0]       out_ch;
  logic [LOGPTS-1:0]    out_bin;
  logic                 out_last;
  logic                 out_ready;
  logic                 err;
  logic [15:0]          frame_cnt;

  always #5 clk = ~clk;

  fft_frame_sched #(.NCH(NCH), .POINTS(POINTS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_grst(grst), .i_ch_req(ch_req), .i_ch_data(ch_data), .o_ch_rd(ch_rd),
    .i_fft_buf_ready(buf_ready), .o_fft_datai_valid(dvalid), .o_fft_datai_re(datai_re),
    .o_fft_datai_im(datai_im), .i_fft_outp_ready(outp_ready), .o_fft_read_outp(read_outp),
    .i_fft_datao_valid(datao_valid), .i_fft_datao_re(datao_re), .i_fft_datao_im(datao_im),
    .i_fft_scale_exp(scale_exp), .o_out_valid(out_valid), .o_out_re(out_re), .o_out_im(out_im),
    .o_out_exp(out_exp), .o_out_ch(out_ch), .o_out_bin(out_bin), .o_out_last(out_last),
    .i_out_ready(out_ready), .o_err(err), .o_frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [NCH-1:0]  req;
    int              gnt;
    int              stall_at;
    int              stall_len;
    int              ord_dly;
    int              drop_at;
    logic [EXPW-1:0] sexp;
  } vec_t;

  typedef struct packed {
    logic [WIDTH-1:0]  re;
    logic [WIDTH-1:0]  im;
    logic [EXPW-1:0]   e;
    logic [CHW-1:0]    ch;
    logic [LOGPTS-1:0] bin;
    logic              last;
  } outrec_t;

  int      n_cmp = 0;
  int      n_err = 0;
  int      exp_fcnt = 0;
  int      exp_pos [NCH];
  outrec_t sb [$];
  vec_t    vt [10];

  // Channel FIFO model: head sample encodes channel number and pop count.
  logic [15:0] fifo_pos [NCH] = '{default: 16'd0};
  always @(posedge clk)
    for (int i = 0; i < NCH; i++) if (ch_rd[CHW'(i)]) fifo_pos[i] <= fifo_pos[i] + 16'd1;

  function automatic logic [WIDTH-1:0] smp(input int ch, input int pos);
    return WIDTH'(ch * 65536 + (pos % 65536));
  endfunction

  always_comb
    for (int i = 0; i < NCH; i++) ch_data[i*WIDTH +: WIDTH] = smp(i, int'(fifo_pos[i]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_frame(input vec_t v);
    int k = 0, st = 0, cyc = 0;
    bit started = 0;
    ch_req = v.req; outp_ready = 1'b0; datao_valid = 1'b0;
    while (k < POINTS && cyc < 2000) begin
      @(negedge clk); cyc++;
      buf_ready = !(k == v.stall_at && st < v.stall_len);
      if (!buf_ready) st++;
      if (k == v.drop_at) ch_req = '0;
      #1;
      if (dvalid) begin
        if (!started) chk("datai_im", 64'(datai_im), 64'(0));
        started = 1;
        chk("load_rd", 64'(ch_rd), 64'(NCH'(1) << v.gnt));
        chk("load_re", 64'(datai_re), 64'(smp(v.gnt, exp_pos[v.gnt])));
        exp_pos[v.gnt]++;
        k++;
      end else if (started) begin
        chk("stall_rd", 64'(ch_rd), 64'(0));
      end
      if (started && k < POINTS) chk("stb_vs_ready", 64'(dvalid), 64'(buf_ready));
    end
    if (k < POINTS) chk("load_count", 64'(k), 64'(POINTS));
    buf_ready = 1'b1;
    ch_req = '0;
  endtask

  task automatic unload_phase(input vec_t v);
    int b = 0, popped = 0, cyc = 0;
    outrec_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); outp_ready = 1'b0; datao_valid = 1'b1; datao_re = WIDTH'($urandom); #1;
      chk("wait_quiet", 64'({ch_rd, dvalid, out_valid, read_outp}), 64'(0));
    end
    for (int i = 0; i < v.ord_dly; i++) begin
      @(negedge clk); outp_ready = 1'b1; out_ready = 1'b0; scale_exp = v.sexp; #1;
      chk("no_read_early", 64'(read_outp), 64'(0));
    end
    @(negedge clk); outp_ready = 1'b1; out_ready = 1'b1; scale_exp = v.sexp; #1;
    chk("no_read_same_cycle", 64'(read_outp), 64'(0));
    @(negedge clk); outp_ready = 1'b0; datao_valid = 1'b0; scale_exp = '0; #1;
    chk("read_outp_pulse", 64'(read_outp), 64'(1));
    chk("out_exp", 64'(out_exp), 64'(v.sexp));
    while (popped < POINTS && cyc < 2000) begin
      @(negedge clk); cyc++;
      datao_valid = 1'b0;
      if (b < POINTS && (cyc % 5) != 0) begin
        datao_valid = 1'b1; datao_re = WIDTH'($urandom); datao_im = WIDTH'($urandom);
        sb.push_back('{re: datao_re, im: datao_im, e: v.sexp, ch: CHW'(v.gnt),
                       bin: LOGPTS'(b), last: (b == POINTS - 1)});
        b++;
      end
      #1;
      if (cyc == 1) chk("read_outp_single", 64'(read_outp), 64'(0));
      if (out_valid) begin
        if (sb.size() == 0) chk("out_unexpected", 64'(out_valid), 64'(0));
        else begin
          e = sb.pop_front();
          chk("out_rec", 64'({out_re, out_im, out_exp, out_ch, out_bin, out_last}), 64'(e));
          popped++;
        end
      end
    end
    datao_valid = 1'b0;
    chk("out_count", 64'(popped), 64'(POINTS));
    exp_fcnt++;
    chk("frame_cnt", 64'(frame_cnt), 64'(exp_fcnt % 65536));
  endtask

  task automatic run_frame(input vec_t v);
    load_frame(v);
    unload_phase(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    vec_t vr;
    for (int i = 0; i < NCH; i++) exp_pos[i] = 0;
    //        req      gnt stall_at len ord drop  exp
    vt[0] = '{4'b1111, 0,  -1,      0,  0,  -1,   4'd3};
    vt[1] = '{4'b1111, 1,  100,     10, 0,  -1,   4'd5};
    vt[2] = '{4'b1111, 2,  -1,      0,  20, -1,   4'd7};
    vt[3] = '{4'b1111, 3,  -1,      0,  0,  -1,   4'd8};
    vt[4] = '{4'b0001, 0,  -1,      0,  0,  -1,   4'd1};
    vt[5] = '{4'b0101, 2,  -1,      0,  0,  -1,   4'd2};
    vt[6] = '{4'b0101, 0,  -1,      0,  0,  -1,   4'd4};
    vt[7] = '{4'b1000, 3,  -1,      0,  0,  30,   4'd9};
    vt[8] = '{4'b1001, 0,  -1,      0,  3,  -1,   4'd15};
    vt[9] = '{4'b0110, 1,  255,     3,  0,  -1,   4'd6};

    grst = 1'b1; ch_req = 4'b1111; buf_ready = 1'b1; outp_ready = 1'b0; out_ready = 1'b1;
    datao_valid = 1'b0; datao_re = '0; datao_im = '0; scale_exp = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobes", 64'({ch_rd, dvalid, read_outp, out_valid, out_last, err}), 64'(0));
    chk("rst_data", 64'({out_re, out_im, out_exp, out_ch, out_bin}), 64'(0));
    chk("rst_datai", 64'(datai_re), 64'(0));
    chk("rst_fcnt", 64'(frame_cnt), 64'(0));
    @(negedge clk); grst = 1'b0; ch_req = '0;

    for (int i = 0; i < 10; i++) run_frame(vt[i]);

    // Reset at sample 50 of a frame granted to channel 2
    ch_req = 4'b1111; k = 0;
    for (int c = 0; c < 400 && k < 50; c++) begin
      @(negedge clk); #1;
      if (dvalid) begin
        chk("pre_rst_rd", 64'(ch_rd), 64'(4'b0100));
        exp_pos[2]++; k++;
      end
    end
    chk("pre_rst_count", 64'(k), 64'(50));
    @(negedge clk); grst = 1'b1; #1;
    chk("rst_gate_now", 64'({ch_rd, dvalid}), 64'(0));
    @(negedge clk); #1;
    chk("midrst_strobes", 64'({ch_rd, dvalid, read_outp, out_valid, out_last, err}), 64'(0));
    chk("midrst_fcnt", 64'(frame_cnt), 64'(0));
    @(negedge clk); grst = 1'b0; ch_req = '0;
    exp_fcnt = 0;
    vr = '{4'b1111, 0, -1, 0, 0, -1, 4'd10};
    run_frame(vr);

    // Result never arrives: timeout after TIMEOUT wait cycles
    vr = '{4'b0010, 1, -1, 0, 0, -1, 4'd0};
    load_frame(vr);
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      @(negedge clk); outp_ready = 1'b0; datao_valid = 1'b1; #1;
      chk("err_timing", 64'(err), 64'(i > TIMEOUT));
      if (i == 1 || i == TIMEOUT) chk("timeout_quiet", 64'({read_outp, out_valid}), 64'(0));
    end
    datao_valid = 1'b0;
    vr = '{4'b0100, 2, -1, 0, 0, -1, 4'd12};
    run_frame(vr);
    chk("err_sticky", 64'(err), 64'(1));

    @(negedge clk); grst = 1'b1;
    @(negedge clk); #1;
    chk("err_cleared", 64'(err), 64'(0));
    chk("fcnt_cleared", 64'(frame_cnt), 64'(0));
    grst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 Parameter NCH, default 4: number of ADC channels sharing one FFT core.
REQ-002 Parameter POINTS, default 256: FFT frame length; LOGPTS = ceil_log2(POINTS).
REQ-003 Parameter WIDTH, default 18: sample/result width.
REQ-004 Parameter TIMEOUT, default 65535: maximum WAIT_RES cycles.
REQ-005 CLK  in  1  sole clock; all logic on rising edge.
REQ-006 GRST  in  1  synchronous, active-high reset.
REQ-007 CH_REQ  in  NCH  channel i FIFO holds at least one full frame.
REQ-008 CH_DATA  in  NCH*WIDTH  show-ahead head sample per channel; channel i at [i*WIDTH +: WIDTH].
REQ-009 CH_RD  out  NCH  one-hot pop strobe to the granted channel FIFO.
REQ-010 FFT_BUF_READY  in  1  core accepts input samples.
REQ-011 FFT_DATAI_VALID  out  1  sample strobe to core.
REQ-012 FFT_DATAI_RE / FFT_DATAI_IM  out  WIDTH each  sample to core; IM constant 0.
REQ-013 FFT_OUTP_READY  in  1  core result available.
REQ-014 FFT_READ_OUTP  out  1  single-cycle unload request.
REQ-015 FFT_DATAO_VALID, FFT_DATAO_RE, FFT_DATAO_IM, FFT_SCALE_EXP  in  1/WIDTH/WIDTH/LOGLOGPTS+1  core results.
REQ-016 OUT_VALID, OUT_RE, OUT_IM, OUT_EXP, OUT_CH, OUT_BIN, OUT_LAST  out  1/WIDTH/WIDTH/exp/ceil_log2(NCH)/LOGPTS/1  tagged result stream.
REQ-017 OUT_READY  in  1  downstream can absorb a full frame without stalling.
REQ-018 ERR  out  1  sticky timeout flag; FRAME_CNT  out  16  completed frames.

Function
REQ-019 FSM states IDLE, LOAD, WAIT_RES, UNLOAD; exactly one frame in flight.
REQ-020 IDLE: if any CH_REQ bit set, grant = first requesting channel strictly after last grant (round robin, wrapping NCH-1 -> 0); register grant; go LOAD next cycle.
REQ-021 LOAD: FFT_DATAI_VALID = CH_RD[grant] = FFT_BUF_READY (combinational); FFT_DATAI_RE = CH_DATA[grant]; other CH_RD bits 0.
REQ-022 FFT_BUF_READY low in LOAD pauses loading; sample counter holds.
REQ-023 Sample counter increments per strobe; after POINTS strobes (counter wraps POINTS-1 -> 0) go WAIT_RES.
REQ-024 CH_REQ deassertion during LOAD is ignored; frame completes.
REQ-025 WAIT_RES: when FFT_OUTP_READY and OUT_READY both high, pulse FFT_READ_OUTP one cycle, latch FFT_SCALE_EXP into OUT_EXP, go UNLOAD.
REQ-026 WAIT_RES cycle counter; reaching TIMEOUT sets ERR, returns IDLE without unload.
REQ-027 UNLOAD: each FFT_DATAO_VALID produces OUT_VALID one cycle later with registered RE/IM, OUT_CH = grant, OUT_BIN = bin counter, OUT_LAST at bin POINTS-1.
REQ-028 After OUT_LAST issued: FRAME_CNT increments (wraps 0xFFFF -> 0), go IDLE; new grant earliest the following cycle.
REQ-029 FFT_DATAO_VALID outside UNLOAD is ignored (OUT_VALID stays 0).
REQ-030 ERR cleared only by GRST.

Reset
REQ-031 GRST high at any clock edge, including mid-frame: state IDLE, last grant NCH-1 (so channel 0 wins first), counters 0, ERR 0, FRAME_CNT 0.
REQ-032 During and after reset: CH_RD, FFT_DATAI_VALID, FFT_READ_OUTP, OUT_VALID, OUT_LAST = 0; data/tag outputs 0.

Structure
REQ-033 Shared package holds FSM state encoding and ceil_log2 function.
REQ-034 One sub-module fft_rr_arbiter (NCH-wide round-robin grant from request and last-grant vector).

Verification
REQ-035 Reset, CH_REQ=0001, BUF_READY=1 -> 256 consecutive CH_RD[0]/DATAI_VALID, state WAIT_RES.
REQ-036 CH_REQ=1111 held, four frames -> grants 0,1,2,3 in order, FRAME_CNT=4.
REQ-037 BUF_READY low for 10 cycles at sample 100 -> exactly 256 strobes total, no data skipped.
REQ-038 OUTP_READY high, OUT_READY low 20 cycles -> no READ_OUTP until OUT_READY; then one pulse; 256 OUT_VALID, OUT_LAST on bin 255, OUT_CH correct.
REQ-039 TIMEOUT=100, OUTP_READY never -> ERR=1 at cycle 100 of WAIT_RES, return IDLE.
REQ-040 GRST asserted at sample 50 of LOAD -> all strobes 0 next cycle; next grant channel 0.
